rr_mux4_arbiter: RTL

Round-robin arbiter that shares one 4:1 data mux among four requesters.
Drives the mux select pair (s1,s0) and a one-hot grant, and registers the selected lane on y.
Sits in front of the structural 4:1 mux datapath; the mux itself is instantiated as a sub-module.
Guarantees fairness with a bounded hold time per grant.

---
 rtl/rr_mux4_arbiter_pkg.sv | 19 +
 rtl/rr_mux4_arbiter_if.sv | 28 ++
 rtl/rr_mux4_arbiter_mux.sv | 23 ++
 rtl/rr_mux4_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
package rr_mux4_arbiter_pkg;

    localparam int LANE_W    = 2;
    localparam int NUM_LANES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        logic [NUM_LANES-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Request/grant/data bundle between requesters and the arbiter.
interface rr_mux4_arbiter_if
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int DW = 1
);
    logic [NUM_LANES-1:0] req;
    logic                 rel;
    logic [DW-1:0]        d0;
    logic [DW-1:0]        d1;
    logic [DW-1:0]        d2;
    logic [DW-1:0]        d3;
    logic [NUM_LANES-1:0] gnt;
    logic                 s1;
    logic                 s0;
    logic [DW-1:0]        y;
    logic                 valid;

    modport master (
        output req, rel, d0, d1, d2, d3,
        input  gnt, s1, s0, y, valid
    );

    modport slave (
        input  req, rel, d0, d1, d2, d3,
        output gnt, s1, s0, y, valid
    );
endinterface

// File: rtl/rr_mux4_arbiter_mux.sv
// DW-wide combinational 4:1 mux selected by {s1,s0}.
module mux4_dw #(
    parameter int DW = 1
) (
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    input  logic          s0,
    input  logic          s1,
    output logic [DW-1:0] y
);
    always_comb begin
        y = '0;
        case ({s1, s0})
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            2'b11:   y = d3;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux; registers grant, select and output.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int DW       = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux4_arbiter_if.slave   bus
);
    localparam int            HCW       = $clog2(HOLD_MAX);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

    state_t               state;
    logic [LANE_W-1:0]    ptr;
    logic [LANE_W-1:0]    sel;
    logic [NUM_LANES-1:0] gnt_r;
    logic [DW-1:0]        y_r;
    logic                 valid_r;
    logic [HCW-1:0]       hold_cnt;

    logic [LANE_W-1:0]    idx;
    logic [LANE_W-1:0]    win;
    logic                 found;
    logic                 release_now;
    logic [DW-1:0]        mux_y;

    mux4_dw #(.DW(DW)) u_mux (
        .d0 (bus.d0),
        .d1 (bus.d1),
        .d2 (bus.d2),
        .d3 (bus.d3),
        .s0 (sel[0]),
        .s1 (sel[1]),
        .y  (mux_y)
    );

    // Scan lanes starting at ptr, wrapping modulo 4; first set request wins.
    always_comb begin
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            idx = ptr + LANE_W'(i);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Forced release only applies once the hold budget is spent and someone else waits.
    always_comb begin
        release_now = bus.rel || !bus.req[sel] ||
                      ((hold_cnt == HOLD_LAST) && ((bus.req & ~gnt_r) != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt_r    <= '0;
            y_r      <= '0;
            valid_r  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_r    <= lane_onehot(win);
                        sel      <= win;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_r   <= '0;
                        valid_r <= 1'b0;
                        y_r     <= '0;
                        ptr     <= sel + LANE_W'(1);
                        state   <= IDLE;
                    end else begin
                        y_r     <= mux_y;
                        valid_r <= 1'b1;
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + HCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.s1    = sel[1];
    assign bus.s0    = sel[0];
    assign bus.y     = y_r;
    assign bus.valid = valid_r;

endmodule
